wb_pwm: RTL and testbench

- Wishbone slave that generates 4 PWM outputs for motor, LED and servo control.
- Attaches to a free conbus slave port, for example s6 at 0x70000000.
- Provides a shared prescaler and period counter, plus per-channel duty registers.
- Period and duty writes are shadowed and take effect only at a period boundary, so outputs never glitch.
- Raises an end-of-period interrupt that feeds one bit of the CPU intr_n vector (inverted at the top level).

---
 rtl/wb_pwm.sv | 182 ++++++++++++++++++
 tb/tb_wb_pwm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pwm.sv
// wb_pwm: Wishbone slave with four PWM channels sharing one prescaler and
// one period counter. PERIOD and DUTYn are shadow registers. Their values
// reach the active copies only at a period wrap, or on every cycle while
// GEN is off, so a running output never sees a partial update.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   wb_adr_i[31:0]     byte address, register index = wb_adr_i[4:2]
//   wb_dat_i/wb_dat_o  write / read data (read data held between reads)
//   wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i   bus request, byte lanes
//   wb_ack_o           one-cycle acknowledge, one clock after the request
//   pwm_o[3:0]         registered PWM outputs
//   intr               registered interrupt level (PDF & IEN)
//
// Register map: 0 CTRL {IEN[9], GEN[8], CHEN[3:0]}, 1 PRESCALE, 2 PERIOD,
// 3..6 DUTY0..3, 7 STATUS {GEN[1] ro, PDF[0] w1c}.
module wb_pwm #(
    parameter int cnt_width = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [3:0]  pwm_o,
    output logic        intr
);
    typedef logic [cnt_width-1:0] cnt_t;
    localparam cnt_t CNT_ONE = cnt_t'(1);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  chen_q, chen_d;
    logic        gen_q, gen_d, ien_q, ien_d;
    cnt_t        prescale_q, prescale_d;
    cnt_t        period_sh_q, period_sh_d, period_act_q, period_act_d;
    cnt_t        duty_sh_q [4];
    cnt_t        duty_sh_d [4];
    cnt_t        duty_act_q [4];
    cnt_t        duty_act_d [4];
    cnt_t        psc_q, psc_d, cnt_q, cnt_d;
    logic        pdf_q, pdf_d;
    logic [3:0]  pwm_q, pwm_d;
    logic        intr_q, intr_d;

    logic        req, wr, rd, pdf_clr, tick, wrap;
    logic [2:0]  idx;
    logic [1:0]  duty_idx;
    logic [31:0] ctrl_rd, ctrl_w, rd_data;
    logic        unused_ok;

    function automatic logic [31:0] merge_sel(input logic [31:0] old,
                                              input logic [31:0] d,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Byte-lane write into a cnt_width field; lanes above the field drop out.
    function automatic cnt_t wr_cnt(input cnt_t old, input logic [31:0] d,
                                    input logic [3:0] sel);
        return cnt_t'(merge_sel(32'(old), d, sel));
    endfunction

    assign req      = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr       = req & wb_we_i;
    assign rd       = req & ~wb_we_i;
    assign idx      = wb_adr_i[4:2];
    assign duty_idx = 2'(idx - 3'd3);
    assign ctrl_rd  = {22'b0, ien_q, gen_q, 4'b0, chen_q};
    assign ctrl_w   = merge_sel(ctrl_rd, wb_dat_i, wb_sel_i);
    assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], ctrl_w[31:10], ctrl_w[7:4]};

    // psc_q can sit above a freshly lowered PRESCALE; >= makes it wrap at once.
    assign tick = gen_q && (psc_q >= prescale_q);
    assign wrap = tick && (cnt_q >= period_act_q);

    always_comb begin
        case (idx)
            3'd0:    rd_data = ctrl_rd;
            3'd1:    rd_data = 32'(prescale_q);
            3'd2:    rd_data = 32'(period_sh_q);
            3'd7:    rd_data = {30'b0, gen_q, pdf_q};
            default: rd_data = 32'(duty_sh_q[duty_idx]);
        endcase
    end

    always_comb begin
        ack_d       = req;
        dat_d       = rd ? rd_data : dat_q;
        chen_d      = chen_q;
        gen_d       = gen_q;
        ien_d       = ien_q;
        prescale_d  = prescale_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        pdf_clr     = 1'b0;
        if (wr) begin
            case (idx)
                3'd0: begin
                    chen_d = ctrl_w[3:0];
                    gen_d  = ctrl_w[8];
                    ien_d  = ctrl_w[9];
                end
                3'd1: prescale_d  = wr_cnt(prescale_q, wb_dat_i, wb_sel_i);
                3'd2: period_sh_d = wr_cnt(period_sh_q, wb_dat_i, wb_sel_i);
                3'd7: pdf_clr     = wb_sel_i[0] & wb_dat_i[0];
                default: duty_sh_d[duty_idx] = wr_cnt(duty_sh_q[duty_idx], wb_dat_i, wb_sel_i);
            endcase
        end

        // Active copies take the pre-write shadows, so a write landing on the
        // wrap edge only shows up one period later.
        psc_d        = '0;
        cnt_d        = '0;
        period_act_d = period_sh_q;
        duty_act_d   = duty_sh_q;
        if (gen_q) begin
            psc_d = tick ? '0 : psc_q + CNT_ONE;
            cnt_d = cnt_q;
            if (tick) cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
            if (!wrap) begin
                period_act_d = period_act_q;
                duty_act_d   = duty_act_q;
            end
        end

        pdf_d = wrap ? 1'b1 : (pdf_clr ? 1'b0 : pdf_q);
        for (int i = 0; i < 4; i++)
            pwm_d[i] = gen_q & chen_q[i] & (cnt_q < duty_act_q[i]);
        intr_d = pdf_q & ien_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            chen_q       <= '0;
            gen_q        <= 1'b0;
            ien_q        <= 1'b0;
            prescale_q   <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            duty_sh_q    <= '{default: '0};
            duty_act_q   <= '{default: '0};
            psc_q        <= '0;
            cnt_q        <= '0;
            pdf_q        <= 1'b0;
            pwm_q        <= '0;
            intr_q       <= 1'b0;
        end else begin
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            chen_q       <= chen_d;
            gen_q        <= gen_d;
            ien_q        <= ien_d;
            prescale_q   <= prescale_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            psc_q        <= psc_d;
            cnt_q        <= cnt_d;
            pdf_q        <= pdf_d;
            pwm_q        <= pwm_d;
            intr_q       <= intr_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign pwm_o    = pwm_q;
    assign intr     = intr_q;
endmodule

// File: tb/tb_wb_pwm.sv
// Directed bench for wb_pwm. pwm_o and intr are logged every cycle, indexed by
// the number of the clock edge that produced them, and the PWM shape is then
// checked against hand-computed edge numbers.
module tb_wb_pwm;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [3:0]  wb_sel_i, pwm_o;
    logic        intr;

    always #5 clk = ~clk;

    wb_pwm #(.cnt_width(16)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
        .pwm_o(pwm_o), .intr(intr)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    logic [3:0] pwm_hist [4096];
    logic       intr_hist [4096];

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) begin
        pwm_hist[cyc_n % 4096]  = pwm_o;
        intr_hist[cyc_n % 4096] = intr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge; the write lands on the next edge (wedge).
    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d,
                            input logic [3:0] s, output int wedge);
        wb_adr_i = {27'b0, idx, 2'b0};
        wb_dat_i = d;
        wb_sel_i = s;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (wb_ack_o) break;
        end
        wedge = cyc_n;
        if (!wb_ack_o) check("wr_ack_timeout", 32'(wb_ack_o), 32'd1);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] d);
        wb_adr_i = {27'b0, idx, 2'b0};
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (wb_ack_o) break;
        end
        if (!wb_ack_o) check("rd_ack_timeout", 32'(wb_ack_o), 32'd1);
        d = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc_n < n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int count_high(input int ch, input int start, input int len);
        int c;
        c = 0;
        for (int k = 0; k < len; k++)
            if (pwm_hist[(start + k) % 4096][ch] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c0, c1, c2, c3, cb;
        logic [31:0] r;
        reset = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Readback with explicit handshake timing; stb held over two edges.
        wb_write(3'd2, 32'h1234, 4'hF, w);
        wb_adr_i = 32'h8; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_stb_i = 1'b1;  wb_cyc_i = 1'b1;
        check("ack_before_edge", 32'(wb_ack_o), 32'd0);
        @(posedge clk); #1;
        check("ack_first_cycle", 32'(wb_ack_o), 32'd1);
        check("rd_period", wb_dat_o, 32'h0000_1234);
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(wb_ack_o), 32'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(posedge clk); #1;

        wb_write(3'd1, 32'hFFFF_FFFF, 4'b0010, w);
        wb_read(3'd1, r);
        check("sel_byte1", r, 32'h0000_FF00);
        wb_write(3'd1, 32'h0, 4'hF, w);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'hF, w);
        wb_read(3'd0, r);
        check("ctrl_unmapped", r, 32'h0000_030F);
        wb_read(3'd7, r);
        check("status_gen", 32'(r[1]), 32'd1);
        wb_write(3'd0, 32'h0, 4'hF, w);

        // Basic PWM, duty change written while cnt=1
        wb_write(3'd2, 32'd9, 4'hF, w);
        wb_write(3'd3, 32'd3, 4'hF, w);
        wb_write(3'd0, 32'h101, 4'hF, c0);
        wb_write(3'd3, 32'd7, 4'hF, w);
        wait_until(c0 + 42);
        check("basic_first_high", 32'(pwm_hist[(c0 + 1) % 4096][0]), 32'd1);
        check("basic_last_high", 32'(pwm_hist[(c0 + 3) % 4096][0]), 32'd1);
        check("basic_first_low", 32'(pwm_hist[(c0 + 4) % 4096][0]), 32'd0);
        check("basic_p0_high", 32'(count_high(0, c0 + 1, 10)), 32'd3);
        check("shadow_p1_high", 32'(count_high(0, c0 + 11, 10)), 32'd7);
        check("shadow_p1_edge", 32'(pwm_hist[(c0 + 18) % 4096][0]), 32'd0);
        check("shadow_p2_high", 32'(count_high(0, c0 + 21, 10)), 32'd7);
        check("shadow_p3_high", 32'(count_high(0, c0 + 31, 10)), 32'd7);
        check("basic_others_low", 32'(count_high(1, c0 + 1, 40) + count_high(2, c0 + 1, 40)
                                      + count_high(3, c0 + 1, 40)), 32'd0);

        // Duty write landing exactly on the wrap edge
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd3, 32'd3, 4'hF, w);
        wb_write(3'd0, 32'h101, 4'hF, c1);
        wait_until(c1 + 9);
        wb_write(3'd3, 32'd7, 4'hF, w);
        wait_until(c1 + 32);
        check("wrapwr_p0_high", 32'(count_high(0, c1 + 1, 10)), 32'd3);
        check("wrapwr_p1_high", 32'(count_high(0, c1 + 11, 10)), 32'd3);
        check("wrapwr_p2_high", 32'(count_high(0, c1 + 21, 10)), 32'd7);

        // Prescaler: (3+1)*(4+1) = 20 clocks per period, 2*5 = 10 high
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd1, 32'd4, 4'hF, w);
        wb_write(3'd2, 32'd3, 4'hF, w);
        wb_write(3'd4, 32'd2, 4'hF, w);
        wb_write(3'd0, 32'h102, 4'hF, c2);
        wait_until(c2 + 42);
        check("psc_p0_high", 32'(count_high(1, c2 + 1, 20)), 32'd10);
        check("psc_p1_high", 32'(count_high(1, c2 + 21, 20)), 32'd10);
        check("psc_last_high", 32'(pwm_hist[(c2 + 10) % 4096][1]), 32'd1);
        check("psc_first_low", 32'(pwm_hist[(c2 + 11) % 4096][1]), 32'd0);
        check("psc_ch0_off", 32'(count_high(0, c2 + 1, 40)), 32'd0);

        // Duty boundaries on channel 2, PERIOD=9, PRESCALE=0
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd1, 32'd0, 4'hF, w);
        wb_write(3'd2, 32'd9, 4'hF, w);
        wb_write(3'd5, 32'd0, 4'hF, w);
        wb_write(3'd0, 32'h104, 4'hF, cb);
        wait_until(cb + 22);
        check("duty0_const_low", 32'(count_high(2, cb + 1, 20)), 32'd0);
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd5, 32'hFFFF, 4'hF, w);
        wb_write(3'd0, 32'h104, 4'hF, cb);
        wait_until(cb + 22);
        check("dutymax_const_high", 32'(count_high(2, cb + 1, 20)), 32'd20);
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd5, 32'd10, 4'hF, w);
        wb_write(3'd0, 32'h104, 4'hF, cb);
        wait_until(cb + 22);
        check("duty_over_period", 32'(count_high(2, cb + 1, 20)), 32'd20);

        // PERIOD=0: a wrap every clock, so PDF is already set and a clear
        // cannot stick
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd7, 32'h1, 4'hF, w);
        wb_read(3'd7, r);
        check("pdf_cleared_idle", r, 32'h0);
        wb_write(3'd2, 32'd0, 4'hF, w);
        wb_write(3'd0, 32'h100, 4'hF, w);
        wb_read(3'd7, r);
        check("period0_pdf_fast", r, 32'h3);
        wb_write(3'd7, 32'h1, 4'hF, w);
        wb_read(3'd7, r);
        check("period0_pdf_again", r, 32'h3);

        // Interrupt: first wrap at edge c3+10, clear at c3+15, wrap-edge clear at c3+30
        wb_write(3'd0, 32'h0, 4'hF, w);
        wb_write(3'd7, 32'h1, 4'hF, w);
        wb_write(3'd2, 32'd9, 4'hF, w);
        wb_write(3'd3, 32'd3, 4'hF, w);
        wb_write(3'd0, 32'h301, 4'hF, c3);
        wait_until(c3 + 14);
        wb_write(3'd7, 32'h1, 4'hF, w);
        wait_until(c3 + 29);
        wb_write(3'd7, 32'h1, 4'hF, w);
        wb_read(3'd7, r);
        check("clr_on_wrap_pdf", r, 32'h3);
        check("intr_before_wrap", 32'(intr_hist[(c3 + 10) % 4096]), 32'd0);
        check("intr_after_wrap", 32'(intr_hist[(c3 + 11) % 4096]), 32'd1);
        check("intr_clear_edge", 32'(intr_hist[(c3 + 15) % 4096]), 32'd1);
        check("intr_dropped", 32'(intr_hist[(c3 + 16) % 4096]), 32'd0);
        check("intr_low_at_wrap", 32'(intr_hist[(c3 + 20) % 4096]), 32'd0);
        check("intr_rearmed", 32'(intr_hist[(c3 + 21) % 4096]), 32'd1);
        check("intr_clr_on_wrap", 32'(intr_hist[(c3 + 32) % 4096]), 32'd1);

        // Reset mid-period while pwm_o[0] is high (cnt just wrapped at c3+30)
        check("pre_rst_pwm", 32'(pwm_o[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_pwm", 32'(pwm_o), 32'd0);
        check("midrst_intr", 32'(intr), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        wb_read(3'd0, r);
        check("midrst_ctrl", r, 32'h0);
        wb_read(3'd2, r);
        check("midrst_period", r, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
